pc_seq_unit: RTL and testbench

//  Parametrised program-counter sequencer for the single-cycle CPU fetch stage.

---
 rtl/pc_seq_unit.sv | 169 ++++++++++++++++
 tb/tb_pc_seq_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the fetch stage: boot hold, stall, redirect, trap, halt/resume.
// Optional return-address stack is compiled in with `define PC_RAS_EN.
module pc_seq_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                INSN_BYTES = 4,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redir_i,
    input  logic [ADDR_W-1:0] redir_addr_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    input  logic              halt_i,
    input  logic              call_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              misalign_o,
    output logic              ras_empty_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    localparam logic [ADDR_W-1:0] INC  = ADDR_W'(INSN_BYTES);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INSN_BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] pc_seq;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;

    assign pc_seq = pc_q + INC;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d, top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run, push;

    assign run     = (state_q == RUN);
    // A call alongside a redirect is a normal jump-and-link, so redirect does not block the push.
    assign push    = run && call_i && !trap_i && !stall_i && (redir_i || !halt_i);
    assign ras_pop = run && ret_i && !trap_i && !redir_i && !stall_i && !halt_i && (cnt_q != '0);
    assign top_idx = (sp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : sp_q - 1'b1;
    assign ras_top = ras_q[top_idx];
    assign ras_empty_o = (cnt_q == '0);

    always_comb begin
        ras_d = ras_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (ras_pop && push) begin
            ras_d[top_idx] = pc_seq;
        end else if (ras_pop) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - 1'b1;
        end else if (push) begin
            // Full stack wraps and overwrites the oldest entry.
            ras_d[sp_q] = pc_seq;
            sp_d = (sp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp_q + 1'b1;
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            ras_q <= ras_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_ras;
    assign unused_ras  = ^{call_i, ret_i, (RAS_DEPTH > 1)};
    assign ras_pop     = 1'b0;
    assign ras_top     = '0;
    assign ras_empty_o = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i && !trap_i && !redir_i) state_d = HALT;
            HALT:    if (trap_i || redir_i) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    logic              load;
    logic [ADDR_W-1:0] tgt;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        load    = 1'b0;
        tgt     = pc_q;
        case (state_q)
            BOOT: begin
                pc_d    = RESET_VEC;
                valid_d = 1'b1;
            end
            RUN: begin
                valid_d = 1'b1;
                if (trap_i) begin
                    load = 1'b1;
                    tgt  = trap_vec_i;
                end else if (redir_i) begin
                    load = 1'b1;
                    tgt  = redir_addr_i;
                end else if (halt_i) begin
                    valid_d = 1'b0;
                end else if (ras_pop) begin
                    load = 1'b1;
                    tgt  = ras_top;
                end else if (!stall_i) begin
                    pc_d = pc_seq;
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (trap_i) begin
                    load = 1'b1;
                    tgt  = trap_vec_i;
                end else if (redir_i) begin
                    load = 1'b1;
                    tgt  = redir_addr_i;
                end
                if (load) valid_d = 1'b1;
            end
            default: valid_d = 1'b0;
        endcase
        if (load) pc_d = tgt;
        misalign_d = load && ((tgt & MASK) != '0);
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit with RESET_VEC=0x100, INSN_BYTES=4.
module tb_pc_seq_unit;
    logic        clk = 0;
    logic        rst_n;
    logic        stall_i, redir_i, trap_i, halt_i, call_i, ret_i;
    logic [31:0] redir_addr_i, trap_vec_i;
    logic [31:0] pc_o;
    logic        pc_valid_o, misalign_o, ras_empty_o;

    int n_chk = 0;
    int n_pass = 0;

    pc_seq_unit #(.ADDR_W(32), .RESET_VEC(32'h100), .INSN_BYTES(4), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redir_i(redir_i),
        .redir_addr_i(redir_addr_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .halt_i(halt_i), .call_i(call_i), .ret_i(ret_i), .pc_o(pc_o),
        .pc_valid_o(pc_valid_o), .misalign_o(misalign_o), .ras_empty_o(ras_empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; redir_i = 0; trap_i = 0; halt_i = 0; call_i = 0; ret_i = 0;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc, input logic v);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_vld"}, {31'b0, pc_valid_o}, {31'b0, v});
    endtask

    initial begin
        idle();
        redir_addr_i = 0; trap_vec_i = 0;
        rst_n = 0;
        step(); step();
        chk_pc("rst", 32'h100, 0);
        chk("rst_mis", {31'b0, misalign_o}, 0);
        chk("rst_ras", {31'b0, ras_empty_o}, 1);

        rst_n = 1;
        step(); chk_pc("boot", 32'h100, 1);
        step(); chk_pc("seq1", 32'h104, 1);
        step(); chk_pc("seq2", 32'h108, 1);

        stall_i = 1;
        for (int i = 0; i < 3; i++) begin step(); chk_pc("stall", 32'h108, 1); end
        redir_i = 1; redir_addr_i = 32'h200;
        step(); chk_pc("stall_redir", 32'h200, 1);
        chk("stall_redir_mis", {31'b0, misalign_o}, 0);
        idle();

        trap_i = 1; trap_vec_i = 32'h80; redir_i = 1; redir_addr_i = 32'h300;
        step(); chk_pc("trap_pri", 32'h80, 1);
        idle();
        redir_i = 1; redir_addr_i = 32'h202;
        step(); chk_pc("mis_tgt", 32'h202, 1);
        chk("mis_set", {31'b0, misalign_o}, 1);
        idle();
        step(); chk_pc("mis_seq", 32'h206, 1);
        chk("mis_clr", {31'b0, misalign_o}, 0);

        redir_i = 1; redir_addr_i = 32'h40;
        step(); chk_pc("to40", 32'h40, 1);
        idle(); halt_i = 1;
        step(); chk_pc("halt", 32'h40, 0);
        idle();
        step(); chk_pc("halt_hold", 32'h40, 0);
        stall_i = 1;
        step(); chk_pc("halt_stall", 32'h40, 0);
        redir_i = 1; redir_addr_i = 32'h500;
        step(); chk_pc("resume", 32'h500, 1);
        idle();
        step(); chk_pc("resume_seq", 32'h504, 1);

        halt_i = 1; redir_i = 1; redir_addr_i = 32'h600;
        step(); chk_pc("halt_redir", 32'h600, 1);
        idle();
        step(); chk_pc("halt_redir_seq", 32'h604, 1);
        halt_i = 1;
        step(); chk_pc("halt2", 32'h604, 0);
        idle(); trap_i = 1; trap_vec_i = 32'h81;
        step(); chk_pc("halt_trap", 32'h81, 1);
        chk("halt_trap_mis", {31'b0, misalign_o}, 1);
        idle();

        redir_i = 1; redir_addr_i = 32'hFFFF_FFFC;
        step(); chk_pc("top", 32'hFFFF_FFFC, 1);
        idle();
        step(); chk_pc("wrap", 32'h0, 1);
        step(); chk_pc("wrap_seq", 32'h4, 1);

        rst_n = 0;
        #1; chk_pc("async_rst", 32'h100, 0);
        redir_i = 1; redir_addr_i = 32'h900;
        step();
        rst_n = 1;
        step(); chk_pc("boot_ignore", 32'h100, 1);
        idle();
        step(); chk_pc("boot_seq", 32'h104, 1);

`ifdef PC_RAS_EN
        redir_i = 1; redir_addr_i = 32'h10;
        step(); chk_pc("ras_to10", 32'h10, 1);
        call_i = 1; redir_addr_i = 32'h400;
        step(); chk_pc("ras_call", 32'h400, 1);
        chk("ras_nonempty", {31'b0, ras_empty_o}, 0);
        idle(); ret_i = 1;
        step(); chk_pc("ras_ret", 32'h14, 1);
        chk("ras_empty", {31'b0, ras_empty_o}, 1);
        idle();
        redir_i = 1; redir_addr_i = 32'h1000;
        step(); idle();
        call_i = 1;
        for (int i = 1; i <= 5; i++) begin
            step(); chk_pc("ras_push", 32'h1000 + 32'(4 * i), 1);
        end
        idle(); ret_i = 1;
        step(); chk_pc("ras_pop1", 32'h1014, 1);
        step(); chk_pc("ras_pop2", 32'h1010, 1);
        step(); chk_pc("ras_pop3", 32'h100C, 1);
        step(); chk_pc("ras_pop4", 32'h1008, 1);
        chk("ras_drained", {31'b0, ras_empty_o}, 1);
        step(); chk_pc("ras_pop_empty", 32'h100C, 1);
        idle();
`else
        call_i = 1; ret_i = 1;
        step(); chk_pc("noras_ignore", 32'h108, 1);
        chk("noras_empty", {31'b0, ras_empty_o}, 1);
        idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
